// File: rtl/sha256_msg_scheduler.sv
// rtl/sha256_msg_scheduler.sv - SHA-256 message schedule generator (W[0]..W[63]) over valid/ready streams

// Schedule-side small sigma0: ROTR7 ^ ROTR18 ^ SHR3
module sigma0_func_for_schedule (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

// Schedule-side small sigma1: ROTR17 ^ ROTR19 ^ SHR10
module sigma1_func_for_schedule (
  input  logic [31:0] x,
  output logic [31:0] y
);
  assign y = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

module sha256_msg_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [5:0]  w_index,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [5:0]  t;
  logic        done_q;

  // 16-entry circular window: slot t&15 holds W[t-16] until overwritten by W[t]
  logic [31:0] wbuf [16];

  logic [3:0]  t_lo;
  logic [3:0]  idx_m2;
  logic [3:0]  idx_m7;
  logic [3:0]  idx_m15;
  logic [31:0] s0_out;
  logic [31:0] s1_out;
  logic [31:0] new_word;
  logic [31:0] emit_word;
  logic        take_in;
  logic        take_w;
  logic        expanding;

  assign t_lo    = t[3:0];
  assign idx_m2  = t_lo - 4'd2;
  assign idx_m7  = t_lo - 4'd7;
  assign idx_m15 = t_lo - 4'd15;

  sigma0_func_for_schedule u_sigma0 (
    .x (wbuf[idx_m15]),
    .y (s0_out)
  );

  sigma1_func_for_schedule u_sigma1 (
    .x (wbuf[idx_m2]),
    .y (s1_out)
  );

  // Carries past bit 31 fall off naturally in the 32-bit sum
  assign new_word  = s1_out + wbuf[idx_m7] + s0_out + wbuf[t_lo];
  assign expanding = (t[5:4] != 2'b00);
  assign emit_word = expanding ? new_word : wbuf[t_lo];

  assign take_in = (state == S_LOAD) && in_valid;
  assign take_w  = (state == S_EMIT) && w_ready;

  assign in_ready = (state == S_LOAD);
  assign w_valid  = (state == S_EMIT);
  assign busy     = (state == S_LOAD) || (state == S_EMIT);
  assign done     = done_q;
  assign w_index  = t;
  // Gate the buffer so nothing uninitialised ever reaches the output outside EMIT
  assign w_data   = (state == S_EMIT) ? emit_word : 32'd0;

  // Control: state, load count, round index and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      t      <= 6'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // The done cycle still counts as the tail of the previous block
          if (start && !done_q) begin
            state <= S_LOAD;
            cnt   <= 4'd0;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state <= S_EMIT;
              t     <= 6'd0;
            end
          end
        end
        S_EMIT: begin
          if (w_ready) begin
            if (t == 6'd63) begin
              state  <= S_IDLE;
              t      <= 6'd0;
              done_q <= 1'b1;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Window storage: loaded words, then each accepted expanded word replaces W[t-16]
  always_ff @(posedge clk) begin
    if (take_in) begin
      wbuf[cnt] <= in_word;
    end else if (take_w && expanding) begin
      wbuf[t_lo] <= new_word;
    end
  end

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// tb/tb_sha256_msg_scheduler.sv - directed self-checking bench for sha256_msg_scheduler

module tb_sha256_msg_scheduler;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [5:0]  w_index;
  logic        busy;
  logic        done;

  int n_checks;
  int n_errors;

  logic [31:0] blk  [16];
  logic [31:0] gold [64];
  logic [31:0] cap  [64];

  sha256_msg_scheduler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_word  (in_word),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_index  (w_index),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_gold();
    for (int i = 0; i < 16; i++) gold[i] = blk[i];
    for (int i = 16; i < 64; i++)
      gold[i] = ss1(gold[i-2]) + gold[i-7] + ss0(gold[i-15]) + gold[i-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_gold();
  endtask

  task automatic set_fill(input logic [31:0] v);
    for (int i = 0; i < 16; i++) blk[i] = v;
    build_gold();
  endtask

  // Starts at a negedge, ends at the negedge after the 16th word is accepted
  task automatic load_block(input bit do_start, input bit stall, input bit abuse);
    int  i;
    int  cyc;
    bit  acc;
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ready_after_start", 32'(in_ready), 32'd1);
      check("busy_in_load", 32'(busy), 32'd1);
    end
    i = 0;
    cyc = 0;
    while (i < 16 && cyc < 400) begin
      if (stall && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_word  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_word  = blk[i];
      end
      if (abuse) start = 1'($urandom_range(0, 1));
      acc = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      if (acc) i++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    check("load_count", 32'(i), 32'd16);
    if (!stall) check("load_cycles", 32'(cyc), 32'd16);
    check("emit_first_valid", 32'(w_valid), 32'd1);
    check("emit_first_index", 32'(w_index), 32'd0);
    check("ready_low_in_emit", 32'(in_ready), 32'd0);
  endtask

  // Starts at a negedge in EMIT, ends at the done negedge (or after a reset at abort_at)
  task automatic emit_block(input bit bp, input bit abuse, input int abort_at);
    int          t;
    int          cyc;
    bit          acc;
    bit          stalled;
    logic [31:0] pd;
    logic [5:0]  pi;
    t = 0;
    cyc = 0;
    stalled = 1'b0;
    pd = 32'd0;
    pi = 6'd0;
    while (t < 64 && cyc < 1000) begin
      if (t == abort_at) begin
        check("abort_index", 32'(w_index), 32'(abort_at));
        start    = 1'b0;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_w_index", 32'(w_index), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      w_ready = bp ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      if (abuse) begin
        start    = 1'($urandom_range(0, 1));
        in_valid = 1'($urandom_range(0, 1));
        in_word  = $urandom;
      end
      check("emit_valid", 32'(w_valid), 32'd1);
      check("emit_busy", 32'(busy), 32'd1);
      check("emit_no_done", 32'(done), 32'd0);
      check("emit_no_ready", 32'(in_ready), 32'd0);
      if (stalled) begin
        check("hold_data", w_data, pd);
        check("hold_index", 32'(w_index), 32'(pi));
      end
      acc = w_valid && w_ready;
      if (acc) begin
        check("w_index", 32'(w_index), 32'(t));
        check($sformatf("w_data[%0d]", t), w_data, gold[t]);
        cap[t] = w_data;
      end
      stalled = w_valid && !w_ready;
      pd = w_data;
      pi = w_index;
      @(negedge clk);
      cyc++;
      if (acc) t++;
    end
    w_ready  = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    check("emit_count", 32'(t), 32'd64);
    if (!bp) check("emit_cycles", 32'(cyc), 32'd64);
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy_low", 32'(busy), 32'd0);
    check("done_no_valid", 32'(w_valid), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_word  = 32'd0;
    w_ready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_w_valid", 32'(w_valid), 32'd0);
    check("reset_w_data", w_data, 32'd0);
    check("reset_w_index", 32'(w_index), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // "abc" block, no stalls
    set_abc();
    load_block(1'b1, 1'b0, 1'b0);
    emit_block(1'b0, 1'b0, 99);
    check("abc_w16", cap[16], 32'h61626380);
    check("abc_w17", cap[17], 32'h000F0000);
    check("abc_w18", cap[18], 32'h7DA86405);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);

    // All ones
    set_fill(32'h00000001);
    load_block(1'b1, 1'b0, 1'b0);
    emit_block(1'b0, 1'b0, 99);
    check("ones_w16", cap[16], 32'h0200E002);
    @(negedge clk);

    // All 0xFFFFFFFF: carries out of bit 31 discarded
    set_fill(32'hFFFFFFFF);
    load_block(1'b1, 1'b0, 1'b0);
    emit_block(1'b0, 1'b0, 99);
    check("ffs_w16", cap[16], 32'h203FFFFC);
    @(negedge clk);

    // "abc" with input stalls and output backpressure
    set_abc();
    load_block(1'b1, 1'b1, 1'b0);
    emit_block(1'b1, 1'b0, 99);
    @(negedge clk);

    // Protocol abuse: in_valid in IDLE captures nothing
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_word = $urandom;
      check("idle_no_ready", 32'(in_ready), 32'd0);
      check("idle_not_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    load_block(1'b1, 1'b1, 1'b1);
    emit_block(1'b1, 1'b1, 99);

    // start on the done cycle is ignored, one cycle later it is accepted
    start = 1'b1;
    @(negedge clk);
    check("done_cycle_start_ignored", 32'(in_ready), 32'd0);
    check("done_cycle_start_idle", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    check("late_start_accepted", 32'(in_ready), 32'd1);

    // Reset mid-EMIT at t=30, then a clean reload
    load_block(1'b0, 1'b0, 1'b0);
    emit_block(1'b0, 1'b0, 30);
    check("post_reset_idle", 32'(busy), 32'd0);
    load_block(1'b1, 1'b0, 1'b0);
    emit_block(1'b0, 1'b0, 99);
    @(negedge clk);
    check("final_done_low", 32'(done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
